// File: rtl/ecc_sched_pkg.sv
// ecc_sched_pkg: shared opcode, op, state and queue-entry types for the ECC issue scheduler.
package ecc_sched_pkg;

    localparam int ECC_XLEN = 64;
    localparam int ECC_ID_W = 4;
    localparam logic [6:0] OPC_CUSTOM1 = 7'b0101011;

    typedef enum logic [2:0] {
        ECC_LOAD = 3'd0,
        ECC_ADD  = 3'd1,
        ECC_SUB  = 3'd2,
        ECC_MUL  = 3'd3,
        ECC_INV  = 3'd4
    } ecc_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } sched_state_e;

    typedef struct packed {
        ecc_op_e               op;
        logic [ECC_ID_W-1:0]   id;
        logic [4:0]            rd;
        logic [ECC_XLEN-1:0]   rs1;
        logic [ECC_XLEN-1:0]   rs2;
        logic                  wb;
    } entry_t;

endpackage

// File: rtl/ecc_issue_fifo.sv
// ecc_issue_fifo: circular in-order issue queue with full/empty/count; Depth must be a power of two.
module ecc_issue_fifo
    import ecc_sched_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  entry_t                 i_data,
    output entry_t                 o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(Depth):0] o_count
);
    localparam int AW = $clog2(Depth);

    entry_t          r_mem [Depth];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_count == (AW+1)'(Depth);
    assign o_empty = r_count == '0;
    assign o_count = r_count;

    // Pointers wrap naturally because Depth is a power of two
    always_ff @(posedge clk_i) begin
        if (rst_i || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

endmodule

// File: rtl/ecc_issue_scheduler.sv
// ecc_issue_scheduler: CV-X-IF custom1 ECC front-end; decodes, queues and sequences ops through the datapath.
// Define ECC_SCHED_TIMEOUT_EN to add a WAIT watchdog that returns an error result after TimeoutCycles.
module ecc_issue_scheduler
    import ecc_sched_pkg::*;
#(
    parameter int XLEN          = ECC_XLEN,
    parameter int IdWidth       = ECC_ID_W,
    parameter int QueueDepth    = 4,
    parameter int TimeoutCycles = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               flush_i,
    output logic               dp_start_o,
    output logic [2:0]         dp_op_o,
    output logic [XLEN-1:0]    dp_opa_o,
    output logic [XLEN-1:0]    dp_opb_o,
    input  logic               dp_done_i,
    input  logic [XLEN-1:0]    dp_result_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [4:0]         result_rd_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic               result_err_o
);
    logic                         w_legal;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_unused;
    logic [$clog2(QueueDepth):0]  w_unused_count;
    entry_t                       w_entry;
    entry_t                       w_head;
    entry_t                       r_cur;
    sched_state_e                 r_state;
    logic                         r_drain;
    logic                         r_start;
    logic                         r_res_valid;
    logic [XLEN-1:0]              r_res_data;

    assign w_legal           = issue_instr_i[6:0] == OPC_CUSTOM1 && issue_instr_i[14:12] <= ECC_INV;
    assign issue_accept_o    = w_legal;
    assign issue_writeback_o = w_legal && issue_instr_i[14:12] != ECC_LOAD;
    assign w_pop             = r_state == S_IDLE && !w_empty && !flush_i;
    // A pop in the same cycle frees a slot, so a full queue can still accept
    assign issue_ready_o     = issue_valid_i && !flush_i && (!w_legal || !w_full || w_pop);
    assign w_push            = issue_ready_o && w_legal;
    assign w_unused          = ^issue_instr_i[31:15];
    assign w_entry           = '{op: ecc_op_e'(issue_instr_i[14:12]), id: issue_id_i, rd: issue_instr_i[11:7],
                                 rs1: issue_rs1_i, rs2: issue_rs2_i, wb: issue_writeback_o};

    ecc_issue_fifo #(.Depth(QueueDepth)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush_i),
        .i_data  (w_entry),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_unused_count)
    );

    assign dp_start_o     = r_start;
    assign dp_op_o        = r_cur.op;
    assign dp_opa_o       = r_cur.rs1;
    assign dp_opb_o       = r_cur.rs2;
    assign result_valid_o = r_res_valid;
    assign result_id_o    = r_cur.id;
    assign result_rd_o    = r_cur.rd;
    assign result_data_o  = r_res_data;

`ifdef ECC_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] r_tmo;
    logic          r_err;
    assign result_err_o = r_err;
`else
    assign result_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_drain     <= 1'b0;
            r_start     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
`ifdef ECC_SCHED_TIMEOUT_EN
            r_tmo       <= '0;
            r_err       <= 1'b0;
`endif
        end else if (flush_i) begin
            // An op already in the datapath must still complete; drain its done pulse
            r_start     <= 1'b0;
            r_res_valid <= 1'b0;
            r_drain     <= r_state == S_WAIT && !dp_done_i;
            r_state     <= (r_state == S_WAIT && !dp_done_i) ? S_WAIT : S_IDLE;
`ifdef ECC_SCHED_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: if (w_pop) begin
                    r_cur   <= w_head;
                    r_start <= 1'b1;
                    r_state <= S_START;
                end
                S_START: begin
                    r_state <= S_WAIT;
`ifdef ECC_SCHED_TIMEOUT_EN
                    r_tmo   <= '0;
`endif
                end
                S_WAIT: if (dp_done_i) begin
                    r_drain     <= 1'b0;
                    r_res_data  <= dp_result_i;
                    r_res_valid <= r_cur.wb && !r_drain;
                    r_state     <= (r_cur.wb && !r_drain) ? S_RESP : S_IDLE;
                end
`ifdef ECC_SCHED_TIMEOUT_EN
                else if (r_tmo == TW'(TimeoutCycles - 1)) begin
                    r_drain     <= 1'b0;
                    r_res_data  <= '0;
                    r_res_valid <= !r_drain;
                    r_err       <= !r_drain;
                    r_state     <= r_drain ? S_IDLE : S_RESP;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
`endif
                S_RESP: if (result_ready_i) begin
                    r_res_valid <= 1'b0;
                    r_state     <= S_IDLE;
`ifdef ECC_SCHED_TIMEOUT_EN
                    r_err       <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_issue_scheduler.sv
// tb_ecc_issue_scheduler: randomized scoreboard bench with a behavioural datapath and op/result model.
module tb_ecc_issue_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i = '0;
    logic [3:0]  issue_id_i = '0;
    logic [63:0] issue_rs1_i = '0;
    logic [63:0] issue_rs2_i = '0;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic        flush_i = 1'b0;
    logic        dp_start_o;
    logic [2:0]  dp_op_o;
    logic [63:0] dp_opa_o;
    logic [63:0] dp_opb_o;
    logic        dp_done_i = 1'b0;
    logic [63:0] dp_result_i = '0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [63:0] result_data_o;
    logic        result_err_o;

    always #5 clk_i = ~clk_i;

    ecc_issue_scheduler dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
        .flush_i(flush_i),
        .dp_start_o(dp_start_o), .dp_op_o(dp_op_o), .dp_opa_o(dp_opa_o), .dp_opb_o(dp_opb_o),
        .dp_done_i(dp_done_i), .dp_result_i(dp_result_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o),
        .result_data_o(result_data_o), .result_err_o(result_err_o)
    );

    typedef struct { logic [3:0] id; logic [4:0] rd; logic [63:0] data; logic err; } res_t;
    typedef struct { logic [2:0] op; logic [63:0] a; logic [63:0] b; } dpx_t;

    res_t res_q[$];
    dpx_t dp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_start = 0;
    bit   dp_stall = 0;
    bit   dp_busy = 0;
    bit   hold_ready = 0;

    function automatic logic [63:0] dp_fn(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a * b;
            3'd4:    return ~a;
            default: return a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: owns result_ready_i and pops the scoreboard on each handshake
    always @(negedge clk_i) begin : res_mon
        res_t e;
        logic r;
        r = !hold_ready && ($urandom_range(0, 3) != 0);
        result_ready_i = r;
        if (!rst_i && result_valid_o === 1'b1 && res_q.size() == 0)
            chk("spurious_result", result_valid_o, 1'b0);
        else if (!rst_i && result_valid_o === 1'b1 && r) begin
            e = res_q.pop_front();
            chk("result_id", result_id_o, e.id);
            chk("result_rd", result_rd_o, e.rd);
            chk("result_data", result_data_o, e.data);
            chk("result_err", result_err_o, e.err);
        end
    end

    // Behavioural datapath: checks each start against issue order, then answers after a random latency
    initial begin
        forever begin : dp_model
            dpx_t e;
            @(negedge clk_i);
            if (!rst_i && dp_start_o === 1'b1) begin
                n_start++;
                if (dp_q.size() == 0)
                    chk("unexpected_start", dp_start_o, 1'b0);
                else begin
                    e = dp_q.pop_front();
                    chk("dp_op", dp_op_o, e.op);
                    chk("dp_opa", dp_opa_o, e.a);
                    chk("dp_opb", dp_opb_o, e.b);
                end
                dp_busy = 1;
                repeat ($urandom_range(1, 4)) @(negedge clk_i);
                while (dp_stall) @(negedge clk_i);
                dp_result_i = dp_fn(dp_op_o, dp_opa_o, dp_opb_o);
                dp_done_i = 1'b1;
                @(negedge clk_i);
                dp_done_i = 1'b0;
                dp_busy = 0;
            end
        end
    end

    task automatic issue(input logic [31:0] instr, input logic [3:0] id, input logic [63:0] a,
                         input logic [63:0] b, input bit blk = 0, input bit tmo = 0);
        logic legal;
        logic wb;
        int   n;
        res_t r;
        dpx_t d;
        legal = instr[6:0] == 7'h2B && instr[14:12] < 3'd5;
        wb = legal && instr[14:12] != 3'd0;
        @(negedge clk_i);
        issue_valid_i = 1'b1;
        issue_instr_i = instr;
        issue_id_i = id;
        issue_rs1_i = a;
        issue_rs2_i = b;
        #1;
        chk("issue_accept", issue_accept_o, legal);
        chk("issue_writeback", issue_writeback_o, wb);
        if (blk) chk("full_queue_blocks", issue_ready_o, 1'b0);
        n = 0;
        while (issue_ready_o !== 1'b1 && n < 300) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("issue_ready", issue_ready_o, 1'b1);
        if (issue_ready_o === 1'b1 && legal) begin
            d.op = instr[14:12];
            d.a = a;
            d.b = b;
            dp_q.push_back(d);
            if (wb || tmo) begin
                r.id = id;
                r.rd = instr[11:7];
                r.data = tmo ? 64'd0 : dp_fn(instr[14:12], a, b);
                r.err = tmo;
                res_q.push_back(r);
            end
        end
        @(posedge clk_i);
        #1;
        issue_valid_i = 1'b0;
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while ((res_q.size() != 0 || dp_q.size() != 0 || dp_busy || result_valid_o) && n < lim) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_outstanding", 64'(res_q.size() + dp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   s;
        int   n;
        bit   stable;
        bit   seen;
        logic [3:0]  cap_id;
        logic [63:0] cap_data;
        logic [31:0] instr;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_issue_ready", issue_ready_o, 1'b0);
        chk("rst_accept", issue_accept_o, 1'b0);
        chk("rst_writeback", issue_writeback_o, 1'b0);
        chk("rst_dp_start", dp_start_o, 1'b0);
        chk("rst_dp_op", dp_op_o, 3'd0);
        chk("rst_dp_opa", dp_opa_o, 64'd0);
        chk("rst_dp_opb", dp_opb_o, 64'd0);
        chk("rst_result_valid", result_valid_o, 1'b0);
        chk("rst_result_id", result_id_o, 4'd0);
        chk("rst_result_rd", result_rd_o, 5'd0);
        chk("rst_result_data", result_data_o, 64'd0);
        chk("rst_result_err", result_err_o, 1'b0);

        issue(32'h0000102B, 4'd3, 64'd5, 64'd7);
        drain(100);

        s = n_start;
        issue(32'h00000033, 4'd1, 64'd1, 64'd2);
        repeat (10) @(negedge clk_i);
        chk("illegal_no_start", 64'(n_start - s), 64'd0);

        issue(32'h0000002B, 4'd1, 64'd9, 64'd0);
        issue(32'h000032AB, 4'd2, 64'd6, 64'd7);
        drain(100);

        dp_stall = 1;
        for (int i = 0; i < 5; i++)
            issue(32'h0000102B | (i << 7), 4'(i), 64'(i * 10), 64'd1);
        fork
            issue(32'h0000202B, 4'd5, 64'd50, 64'd8, 1'b1);
            begin repeat (6) @(negedge clk_i); dp_stall = 0; end
        join
        drain(500);

        hold_ready = 1;
        issue(32'h0000112B, 4'd7, 64'd100, 64'd23);
        n = 0;
        while (result_valid_o !== 1'b1 && n < 50) begin @(negedge clk_i); n++; end
        chk("bp_result_valid", result_valid_o, 1'b1);
        cap_id = result_id_o;
        cap_data = result_data_o;
        s = n_start;
        stable = 1;
        fork
            for (int i = 0; i < 4; i++)
                issue(32'h0000302B, 4'(8 + i), 64'(i + 3), 64'(i + 5));
            repeat (10) begin
                @(negedge clk_i);
                if (result_valid_o !== 1'b1 || result_id_o !== cap_id || result_data_o !== cap_data) stable = 0;
            end
        join
        chk("bp_outputs_stable", stable, 1'b1);
        chk("bp_no_new_start", 64'(n_start - s), 64'd0);
        fork
            issue(32'h0000402B, 4'd12, 64'hF0F0, 64'd0, 1'b1);
            begin repeat (4) @(negedge clk_i); hold_ready = 0; end
        join
        drain(500);

        dp_stall = 1;
        for (int i = 1; i < 4; i++)
            issue(32'h0000102B, 4'(i), 64'(i), 64'(i));
        n = 0;
        while (!dp_busy && n < 50) begin @(negedge clk_i); n++; end
        repeat (2) @(negedge clk_i);
        flush_i = 1'b1;
        issue_valid_i = 1'b1;
        issue_instr_i = 32'h0000102B;
        #1;
        chk("flush_blocks_issue", issue_ready_o, 1'b0);
        res_q.delete();
        dp_q.delete();
        @(negedge clk_i);
        flush_i = 1'b0;
        issue_valid_i = 1'b0;
        dp_stall = 0;
        s = n_start;
        seen = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (result_valid_o !== 1'b0) seen = 1;
        end
        chk("flush_no_result", seen, 1'b0);
        chk("flush_no_start", 64'(n_start - s), 64'd0);
        chk("flush_dp_done_consumed", dp_busy, 1'b0);

        for (int i = 0; i < 80; i++) begin
            instr = $urandom;
            if ($urandom_range(0, 9) != 0) instr[6:0] = 7'h2B;
            issue(instr, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end
        drain(3000);

`ifdef ECC_SCHED_TIMEOUT_EN
        dp_stall = 1;
        issue(32'h0000152B, 4'd9, 64'd11, 64'd22, 1'b0, 1'b1);
        n = 0;
        while (res_q.size() != 0 && n < 1300) begin @(negedge clk_i); n++; end
        chk("timeout_result_returned", 64'(res_q.size()), 64'd0);
        dp_stall = 0;
        drain(100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
